// File: rtl/spi_pkg.sv
// spi_pkg: shared sample width, frame length and sample type for the SPI sample collector.
package spi_pkg;
    localparam int SAMPLE_W   = 12;
    localparam int FRAME_BITS = SAMPLE_W + 1;
    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two FIFO with push/pop, full/empty, occupancy level and a flop-backed head.
module sample_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign full   = level == (AW+1)'(DEPTH);
    assign empty  = level == '0;
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign head   = mem[rdPtr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) mem[wrPtr] <= din;
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop) rdPtr <= rdPtr + AW'(1);
            level <= level + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end
endmodule

// File: rtl/spi_sample_collector.sv
// spi_sample_collector: deserialises null-bit-led MSB-first ADC frames into a sample FIFO.
// Optional averaging of 2**AVG_LOG2 samples per output when SPI_SAMPLE_AVG_EN is defined.
module spi_sample_collector
    import spi_pkg::*;
#(
    parameter int NUM_BITS   = SAMPLE_W,
    parameter int FIFO_DEPTH = 8
`ifdef SPI_SAMPLE_AVG_EN
    ,parameter int AVG_LOG2  = 2
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miso,
    input  logic                          dataInEnable,
    input  logic                          dataOutValid,
    output logic [NUM_BITS-1:0]           sampleData,
    output logic                          sampleValid,
    input  logic                          sampleReady,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic                          overflow,
    output logic                          frameErr,
    input  logic                          errClear
);
    localparam int FRAME = NUM_BITS + 1;
    localparam int CW    = $clog2(FRAME + 1);
    // The null bit is only counted, never stored: it would fall off the top of shreg anyway.
    logic [NUM_BITS-1:0] shreg;
    logic [CW-1:0] bitCnt;
    logic good, bad, push, pop, full, empty;
    logic [NUM_BITS-1:0] pushData;
    assign good = dataOutValid & (bitCnt == CW'(FRAME));
    assign bad  = dataOutValid & (bitCnt != CW'(FRAME));
    assign pop  = sampleValid & sampleReady;
    assign sampleValid = ~empty;
`ifdef SPI_SAMPLE_AVG_EN
    localparam int AW = NUM_BITS + AVG_LOG2;
    logic [AW-1:0] acc, accNext;
    logic [AVG_LOG2-1:0] avgCnt;
    assign accNext  = acc + AW'(shreg);
    assign push     = good & (&avgCnt);
    assign pushData = accNext[AW-1:AVG_LOG2];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            avgCnt <= '0;
        end else if (good) begin
            acc    <= &avgCnt ? '0 : accNext;
            avgCnt <= avgCnt + AVG_LOG2'(1);
        end
    end
`else
    assign push     = good;
    assign pushData = shreg;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            bitCnt   <= '0;
            overflow <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            if (dataInEnable) shreg <= {shreg[NUM_BITS-2:0], miso};
            if (dataOutValid) bitCnt <= dataInEnable ? CW'(1) : '0;
            else if (dataInEnable && bitCnt != CW'(FRAME)) bitCnt <= bitCnt + CW'(1);
            overflow <= (push & full & ~pop) | (overflow & ~errClear);
            frameErr <= bad | (frameErr & ~errClear);
        end
    end
    sample_fifo #(.WIDTH(NUM_BITS), .DEPTH(FIFO_DEPTH)) fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pushData),
        .head(sampleData), .full(full), .empty(empty), .level(fifoLevel)
    );
endmodule
